uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//  Receive side of the UART link: recovers asynchronous serial frames from rx_in and presents each byte in parallel.
//  Frame format is 1 start bit (0), DATA_W data bits LSB first, an optional parity bit, and 1 stop bit (1).
//  Bit timing comes from an oversampling strobe, sample_tick, produced by the shared baud generator.
//  The block sits between the pad and the RX FIFO/consumer.
// PARAMETERS
//  DATA_W      8   data bits per frame
//  OVERSAMPLE  16  sample_tick pulses per bit period; must be even and >= 4
//  PARITY_ODD  0   0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  rx_in          in   1       serial line, idles high, asynchronous to clk
//  sample_tick    in   1       1-cycle strobe at OVERSAMPLE x baud rate
//  data_out       out  DATA_W  last received byte, held until the next frame completes
//  data_valid     out  1       1-cycle pulse when data_out is updated with a good frame
//  busy           out  1       high while a frame is in progress (any state except IDLE)
//  framing_error  out  1       1-cycle pulse when the stop bit is sampled as 0
//  parity_error   out  1       1-cycle pulse on parity mismatch; only present with UART_RX_PARITY_EN
// BEHAVIOUR
//  Reset (asynchronous, rst=0):
//   state=IDLE, synchronizer flops=1, data_out=0; data_valid, busy and both error outputs are 0.
//   Reset mid-frame discards the partial byte.
//  Input synchronization: rx_in passes through a 2-flop synchronizer; all decisions use the synced value rx_s.
//  Tick counter tick_cnt (width $clog2(OVERSAMPLE)) advances only on sample_tick and clears on every state change.
//  Bit counter bit_cnt (width $clog2(DATA_W)+1).
//  State machine, with all transitions on the clk edge:
//   IDLE:      rx_s==0 -> START; tick_cnt cleared.
//   START:     at tick_cnt==OVERSAMPLE/2-1 on sample_tick (mid start bit):
//              rx_s==0 -> DATA with bit_cnt=0;
//              rx_s==1 -> IDLE (glitch rejected; no output pulse).
//   DATA:      every OVERSAMPLE ticks (mid bit), shift rx_s into shift_reg MSB and shift right (LSB first), then bit_cnt++.
//              When bit_cnt reaches DATA_W: go to PARITY if the macro is defined, else STOP.
//   PARITY:    after OVERSAMPLE ticks, sample rx_s into par_bit -> STOP.
//   STOP:      after OVERSAMPLE ticks, sample rx_s:
//              rx_s==1 -> data_out<=shift_reg, data_valid=1 for the next cycle, -> IDLE;
//              rx_s==0 -> framing_error=1 for one cycle, data_out unchanged, -> BREAK.
//   BREAK:     wait for rx_s==1 -> IDLE; this prevents a held-low line from re-triggering START.
//  Latency: data_valid and the error pulses go high 1 clk after the stop-bit sample_tick.
//  A new start edge is accepted in the cycle after returning to IDLE.
//  Back-to-back frames: no idle gap is required beyond the stop bit.
//  sample_tick held continuously high is legal; timing is then clk-based.
//  rx_in toggling while busy is ignored except at the sample points.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   PARITY state, parity_error port and the PARITY_ODD check are present.
//   Expected parity = ^shift_reg ^ PARITY_ODD.
//   On mismatch with a good stop bit: parity_error pulses with data_valid, and data_out is updated.
//   If the stop bit is also bad, framing_error takes precedence and parity_error stays 0.
//  UART_RX_PARITY_EN undefined: the parity_error port and PARITY state are absent; frames are DATA_W+2 bits.
// STRUCTURE
//  uart_pkg holds the state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), the default DATA_W/OVERSAMPLE localparams,
//   and the parity-type constants; it is shared with the TX side.
//  One sub-module: uart_sync_2ff, the 2-flop synchronizer with reset value 1; it is reusable for other async inputs.
// TESTING (OVERSAMPLE=16, sample_tick every clk unless stated)
//  1. Frame 0xA5 with a good stop bit -> data_valid pulse 1 clk after the stop sample; data_out=0xA5, busy low after.
//  2. rx_in low for 5 ticks then high -> START aborts to IDLE; no data_valid, busy drops, data_out unchanged.
//  3. Frame 0x3C with the stop bit forced 0 and the line held low 40 ticks -> framing_error pulse.
//     data_out keeps its prior value; no new frame until the line goes high.
//  4. Two back-to-back frames 0x00 then 0xFF -> two data_valid pulses, data_out 0x00 then 0xFF.
//  5. rst asserted mid-DATA after 3 bits of 0x55 -> busy=0 and data_out=0 immediately.
//     Next full frame 0x81 is received correctly.
//  6. With UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity bit 0 -> parity_error and data_valid together; parity 1 -> data_valid only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default sizes and parity types.
// Used by the RX deserializer and the TX side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// UART RX bundle: pad-side inputs (rx_in, sample_tick) and byte-side outputs.
// master = deserializer, slave = pad/consumer; parity_error only with UART_RX_PARITY_EN.
interface uart_rx_deserializer_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);

  logic              rx_in;
  logic              sample_tick;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              framing_error;
`ifdef UART_RX_PARITY_EN
  logic              parity_error;
`endif

  modport master (
    input  rx_in,
    input  sample_tick,
`ifdef UART_RX_PARITY_EN
    output parity_error,
`endif
    output data_out,
    output data_valid,
    output busy,
    output framing_error
  );

  modport slave (
    output rx_in,
    output sample_tick,
`ifdef UART_RX_PARITY_EN
    input  parity_error,
`endif
    input  data_out,
    input  data_valid,
    input  busy,
    input  framing_error
  );

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst (async active-low), d (async in), q (synced out); resets to RST_VAL.
module uart_sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start/data/[parity]/stop framing from an oversampling tick.
// Ports: clk, rst (async active-low), bus (uart_rx_deserializer_if.master). Option: UART_RX_PARITY_EN.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input logic                   clk,
  input logic                   rst,
  uart_rx_deserializer_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W) + 1;

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  logic              rx_s;
  uart_state_t       state;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              ferr_q;
  logic              mid;
  logic              full;
`ifdef UART_RX_PARITY_EN
  logic              par_bit;
  logic              perr_q;
`endif

  uart_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_in),
    .q   (rx_s)
  );

  // Sample points: middle of the start bit, then one full bit later.
  assign mid  = bus.sample_tick && (tick_cnt == T_MID);
  assign full = bus.sample_tick && (tick_cnt == T_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      if (bus.sample_tick)
        tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (mid) begin
            tick_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (full) begin
            shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == B_LAST) begin
              tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state    <= PARITY;
`else
              state    <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (full) begin
            par_bit  <= rx_s;
            tick_cnt <= '0;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (full) begin
            tick_cnt <= '0;
            if (rx_s) begin
              data_q  <= shift_reg;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= IDLE;
`ifdef UART_RX_PARITY_EN
              perr_q  <= par_bit != ((^shift_reg) ^ PARITY_ODD);
`endif
            end else begin
              // Bad stop: park until the line idles so a held-low
              // line cannot look like a fresh start bit.
              ferr_q <= 1'b1;
              state  <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            tick_cnt <= '0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tick_cnt <= '0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out      = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.busy          = busy_q;
  assign bus.framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = perr_q;
`endif

endmodule
